// File: rtl/asic_analyzer_pkg.sv
// Shared types and constants for the XADC output analyzer.
package asic_analyzer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACC,
    CMP,
    PUB
  } state_t;

  localparam logic [6:0] DRP_AUX_BASE = 7'h10;
  localparam int         ADC_W        = 12;

endpackage

// File: rtl/channel_argmax.sv
// Serial running-maximum tracker: one (idx, value) pair per enabled cycle.
// max_idx/max_val include the current input, so the final winner is visible
// combinationally during the last compare cycle. Ties keep the earlier index.
module channel_argmax
  import asic_analyzer_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int VAL_W = ADC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [VAL_W-1:0] value,
  output logic [IDX_W-1:0] max_idx,
  output logic [VAL_W-1:0] max_val
);

  logic [IDX_W-1:0] run_idx;
  logic [VAL_W-1:0] run_val;

  // Candidate winner: restart on start, otherwise replace only on strictly greater
  always_comb begin
    max_idx = run_idx;
    max_val = run_val;
    if (start || (value > run_val)) begin
      max_idx = idx;
      max_val = value;
    end
  end

  // Hold the running maximum between compare cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      run_idx <= '0;
      run_val <= '0;
    end else if (en) begin
      run_idx <= max_idx;
      run_val <= max_val;
    end
  end

endmodule

// File: rtl/asic_output_analyzer.sv
// Scans XADC aux channels over DRP after each end-of-sequence, averages
// 2^AVG_LOG2 scans per channel and publishes the strongest channel.
module asic_output_analyzer
  import asic_analyzer_pkg::*;
#(
  parameter int             NUM_CH      = 4,
  parameter int             AVG_LOG2    = 2,
  parameter logic [11:0]    THRESHOLD   = 12'h400,
  parameter int             DRP_TIMEOUT = 255,
  localparam int            CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [6:0]    daddr,
  output logic          den,
  output logic          dwe,
  output logic [15:0]   di,
  input  logic [15:0]   do_in,
  input  logic          drdy,
  input  logic          eos,
  output logic [CW-1:0] network_output,
  output logic [11:0]   max_value,
  output logic          result_valid,
  output logic          no_winner,
  output logic          busy,
  output logic          timeout_err
);

  localparam int AW = ADC_W + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;
  localparam int TW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [SW-1:0] LAST_SCAN = SW'((1 << AVG_LOG2) - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(DRP_TIMEOUT - 1);

  state_t           state;
  logic [CW-1:0]    ch;
  logic [CW-1:0]    cmp_idx;
  logic [SW-1:0]    scan_cnt;
  logic [TW-1:0]    tcnt;
  logic [ADC_W-1:0] sample;
  logic [AW-1:0]    acc [NUM_CH];
  logic [ADC_W-1:0] avg_cur;
  logic [CW-1:0]    best_idx;
  logic [ADC_W-1:0] best_val;
  logic             cmp_en;
  logic             cmp_start;
  logic             unused_bits;

  assign dwe         = 1'b0;
  assign di          = 16'h0000;
  assign busy        = (state != IDLE);
  assign unused_bits = ^do_in[3:0];

  assign avg_cur   = ADC_W'(acc[cmp_idx] >> AVG_LOG2);
  assign cmp_en    = (state == CMP);
  assign cmp_start = cmp_en && (cmp_idx == '0);

  channel_argmax #(
    .IDX_W (CW),
    .VAL_W (ADC_W)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .start   (cmp_start),
    .en      (cmp_en),
    .idx     (cmp_idx),
    .value   (avg_cur),
    .max_idx (best_idx),
    .max_val (best_val)
  );

  // Main sequencer: DRP reads, accumulation, serial compare and publish
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      den            <= 1'b0;
      daddr          <= '0;
      network_output <= '0;
      max_value      <= '0;
      result_valid   <= 1'b0;
      no_winner      <= 1'b0;
      timeout_err    <= 1'b0;
      ch             <= '0;
      cmp_idx        <= '0;
      scan_cnt       <= '0;
      tcnt           <= '0;
      sample         <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      den          <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (eos) begin
            ch    <= '0;
            den   <= 1'b1;
            daddr <= DRP_AUX_BASE;
            state <= REQ;
          end
        end
        REQ: begin
          tcnt  <= TW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (drdy) begin
            sample <= do_in[15:4];
            state  <= ACC;
          end else if (tcnt >= TO_LIMIT) begin
            timeout_err <= 1'b1;
            scan_cnt    <= '0;
            tcnt        <= '0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ACC: begin
          acc[ch] <= acc[ch] + AW'(sample);
          if (ch != LAST_CH) begin
            ch    <= ch + 1'b1;
            den   <= 1'b1;
            daddr <= DRP_AUX_BASE + 7'(ch) + 7'd1;
            state <= REQ;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (scan_cnt == LAST_SCAN) begin
              cmp_idx <= '0;
              state   <= CMP;
            end else begin
              state <= IDLE;
            end
          end
        end
        CMP: begin
          if (cmp_idx == LAST_CH) begin
            if (best_val >= THRESHOLD) begin
              network_output <= best_idx;
              max_value      <= best_val;
              no_winner      <= 1'b0;
            end else begin
              no_winner <= 1'b1;
            end
            result_valid <= 1'b1;
            state        <= PUB;
          end else begin
            cmp_idx <= cmp_idx + 1'b1;
          end
        end
        PUB: begin
          scan_cnt <= '0;
          cmp_idx  <= '0;
          for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/asic_output_analyzer.md
ASIC_OUTPUT_ANALYZER -- requirements
Module: asic_output_analyzer

Interface
REQ-001 Parameter NUM_CH, default 4, number of XADC aux channels scanned; legal range 2..16.
REQ-002 Parameter AVG_LOG2, default 2, log2 of the number of scans averaged per decision; legal range 0..4.
REQ-003 Parameter THRESHOLD, default 12'h400, minimum averaged code for a valid winner.
REQ-004 Parameter DRP_TIMEOUT, default 255, maximum number of cycles to wait for drdy.
REQ-005 Port clk, input, 1, single clock for all logic; also drives the XADC DCLK.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port daddr, output, 7, DRP address.
REQ-008 Port den, output, 1, DRP enable strobe.
REQ-009 Port dwe, output, 1, DRP write enable; held 0.
REQ-010 Port di, output, 16, DRP write data; held 0.
REQ-011 Port do_in, input, 16, DRP read data.
REQ-012 Port drdy, input, 1, DRP data ready.
REQ-013 Port eos, input, 1, XADC end-of-sequence pulse.
REQ-014 Port network_output, output, CW=max(1,$clog2(NUM_CH)), index of the winning channel.
REQ-015 Port max_value, output, 12, averaged code of the winning channel.
REQ-016 Port result_valid, output, 1, one-cycle pulse when a decision is published.
REQ-017 Port no_winner, output, 1, set when the last decision fell below THRESHOLD.
REQ-018 Port busy, output, 1, high in every state except IDLE.
REQ-019 Port timeout_err, output, 1, one-cycle pulse when a frame is aborted because drdy never arrived.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, ACC, CMP and PUB.
REQ-021 IDLE: on an eos pulse, the block SHALL set ch=0 and go to REQ; eos seen in any other state SHALL be ignored.
REQ-022 REQ: the block SHALL assert den for exactly one cycle with daddr=7'h10+ch, then go to WAIT.
REQ-023 WAIT: on drdy the block SHALL go to ACC; a drdy arriving outside WAIT SHALL be ignored.
REQ-024 WAIT: after DRP_TIMEOUT cycles with no drdy, the block SHALL pulse timeout_err, clear all accumulators and the scan count, and go to IDLE.
REQ-025 ACC: the block SHALL add do_in[15:4] into acc[ch]; each accumulator is 12+AVG_LOG2 bits wide and cannot overflow.
REQ-026 ACC exit: if ch<NUM_CH-1, the block SHALL increment ch and go to REQ.
REQ-027 ACC exit: if ch=NUM_CH-1, the block SHALL increment the scan count.
REQ-028 ACC exit: when the scan count reaches 2^AVG_LOG2, the block SHALL go to CMP; otherwise it SHALL go to IDLE.
REQ-029 CMP: the block SHALL scan serially, one channel per cycle, over NUM_CH cycles, comparing avg=acc>>AVG_LOG2 (truncated).
REQ-030 CMP: on a tie the lowest channel index SHALL win (strict greater-than replaces the running maximum).
REQ-031 PUB: if max>=THRESHOLD, the block SHALL update network_output and max_value and clear no_winner.
REQ-032 PUB: if max<THRESHOLD, the block SHALL set no_winner and leave network_output and max_value at their previous values.
REQ-033 PUB: the block SHALL pulse result_valid, clear all accumulators and the scan count, and return to IDLE.
REQ-034 Latency: result_valid SHALL assert exactly NUM_CH+1 cycles after the final ACC cycle of a frame.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-036 Reset values SHALL be: den=0, daddr=0, dwe=0, di=0, network_output=0, max_value=0, result_valid=0, no_winner=0, busy=0, timeout_err=0, all accumulators=0, ch=0, scan count=0, timeout counter=0.
REQ-037 A reset asserted mid-frame SHALL discard the partial frame.
REQ-038 A drdy returning after a mid-frame reset SHALL have no effect.

Structure
REQ-039 Package asic_analyzer_pkg SHALL hold the state enum, DRP_AUX_BASE=7'h10 and ADC_W=12.
REQ-040 Sub-module channel_argmax SHALL implement the serial compare: start, idx/value inputs, and max_idx/max_val outputs.

Verification
REQ-041 Defaults, constant codes ch0..3 = 12'h100, 12'h900, 12'h500, 12'h200 over 4 eos -> result_valid once, network_output=1, max_value=12'h900, no_winner=0.
REQ-042 All channels = 12'h3FF -> no_winner=1, and network_output/max_value keep their prior values (1 / 12'h900 after the first test).
REQ-043 Tie: ch2=ch3=12'hA00 with others lower -> network_output=2.
REQ-044 drdy withheld on ch1 -> timeout_err pulses 255 cycles after den, busy drops, no result_valid, and the next frame starts from clean accumulators.
REQ-045 rst during WAIT of scan 3, followed by a late drdy -> all outputs return to reset values and the next 4 eos produce a correct decision.
REQ-046 NUM_CH=16, AVG_LOG2=0, ch7 highest at 12'hFFF -> network_output=7 one frame after a single eos.
